ones_pattern_builder: RTL and testbench

- Inverse of the bit-counting datapath: takes a ones-count k and builds an N-bit word that contains exactly k ones.
- The ones are shifted serially into the LSB end, giving the thermometer code 2^k-1.
- The result feeds the bit counter as a round-trip self-check source.
- Control is ASM-style (three states), driven by the same start switch.

---
 rtl/ones_pattern_builder_pkg.sv | 18 +
 rtl/ones_pattern_builder_down_counter.sv | 40 ++++
 rtl/ones_pattern_builder.sv | 119 +++++++++++
 tb/tb_ones_pattern_builder.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/ones_pattern_builder_pkg.sv
// Shared definitions for the ones-pattern builder: FSM state encoding
// (identical to the bit counter's encoding) and the k_eff helper.
package ones_pattern_builder_pkg;

    // Three-state ASM control; 2'b11 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BUILD = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    // Saturating minimum: a requested count larger than the word width
    // is clamped to the width, so a run never shifts more than n times.
    function automatic int unsigned sat_min(input int unsigned k, input int unsigned n);
        return (k > n) ? n : k;
    endfunction

endpackage

// File: rtl/ones_pattern_builder_down_counter.sv
// Loadable CW-bit down-counter holding the number of ones still to insert.
// Load has priority over decrement; decrement stops at zero (no wrap).
module ones_pattern_builder_down_counter #(
    parameter int unsigned CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          zero
);

    logic [CW-1:0] count_d;
    logic [CW-1:0] count_q;

    // Next count: load wins, otherwise decrement only while non-zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - CW'(1);
        end
    end

    // Count register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/ones_pattern_builder.sv
// Builds an N-bit thermometer word with exactly k_eff = min(count_in, N)
// ones, shifted serially into the LSB. Start is level-sensitive: s high in
// IDLE launches a run, and DONE is left only once s is released.
//
// Handshake: s acts as a request level; busy is high for the whole run
// (k_eff+1 cycles), done is high from completion until s drops. A run
// always completes once started; s and count_in are ignored in BUILD.
module ones_pattern_builder
    import ones_pattern_builder_pkg::*;
#(
    parameter int unsigned N  = 8,
    parameter int unsigned CW = 4
) (
    input  logic          clk,
    input  logic          areset_n,
    input  logic          s,
    input  logic [CW-1:0] count_in,
    output logic [N-1:0]  pattern,
    output logic [CW-1:0] ones_shifted,
    output logic          busy,
    output logic          done,
    output logic          sat
);

    localparam logic [CW-1:0] N_CW = CW'(N);

    state_e        state_d, state_q;
    logic [N-1:0]  pattern_d, pattern_q;
    logic [CW-1:0] ones_shifted_d, ones_shifted_q;
    logic          sat_d, sat_q;

    logic          cnt_load;
    logic          cnt_dec;
    logic [CW-1:0] k_eff;
    logic [CW-1:0] remaining;
    logic          remaining_zero;

    assign k_eff = CW'(sat_min(32'(count_in), N));

    // remaining lives in the down-counter; reloaded every IDLE edge.
    ones_pattern_builder_down_counter #(
        .CW(CW)
    ) u_remaining (
        .clk      (clk),
        .rst_n    (areset_n),
        .load     (cnt_load),
        .load_val (k_eff),
        .dec      (cnt_dec),
        .count    (remaining),
        .zero     (remaining_zero)
    );

    // Next-state, datapath next values and Moore outputs.
    always_comb begin
        state_d        = state_q;
        pattern_d      = pattern_q;
        ones_shifted_d = ones_shifted_q;
        sat_d          = sat_q;
        cnt_load       = 1'b0;
        cnt_dec        = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_load = 1'b1;
                sat_d    = (count_in > N_CW);
                if (s) begin
                    state_d        = ST_BUILD;
                    pattern_d      = '0;
                    ones_shifted_d = '0;
                end
            end
            ST_BUILD: begin
                busy = 1'b1;
                if (!remaining_zero) begin
                    pattern_d      = {pattern_q[N-2:0], 1'b1};
                    cnt_dec        = 1'b1;
                    ones_shifted_d = ones_shifted_q + CW'(1);
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (!s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                // Unused encoding: outputs as IDLE, recover next edge.
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q        <= ST_IDLE;
            pattern_q      <= '0;
            ones_shifted_q <= '0;
            sat_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            pattern_q      <= pattern_d;
            ones_shifted_q <= ones_shifted_d;
            sat_q          <= sat_d;
        end
    end

    assign pattern      = pattern_q;
    assign ones_shifted = ones_shifted_q;
    assign sat          = sat_q;

    // Debug visibility of the FSM for checkers bound to this module.
    logic [1:0] state_dbg;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_ones_pattern_builder.sv
// Directed plus randomized bench for ones_pattern_builder. Expected values
// come from the arithmetic definition: k_eff = min(k, 8), final word
// 2^k_eff - 1, k_eff+1 busy cycles, popcount(word) == k_eff.
module tb_ones_pattern_builder;

    logic       clk;
    logic       areset_n;
    logic       s;
    logic [3:0] count_in;
    logic [7:0] pattern;
    logic [3:0] ones_shifted;
    logic       busy;
    logic       done;
    logic       sat;

    int tests;
    int failed;

    ones_pattern_builder #(.N(8), .CW(4)) dut (
        .clk          (clk),
        .areset_n     (areset_n),
        .s            (s),
        .count_in     (count_in),
        .pattern      (pattern),
        .ones_shifted (ones_shifted),
        .busy         (busy),
        .done         (done),
        .sat          (sat)
    );

    // Clock: 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // One full run: launch with count k, follow BUILD, check DONE, return
    // to IDLE. With disturb, count_in changes and s drops mid-run.
    task automatic run(input logic [3:0] k, input int done_hold, input bit disturb);
        int keff;
        int j;
        int m;
        int exp_word;
        keff     = (k > 4'd8) ? 8 : int'(k);
        exp_word = (1 << keff) - 1;
        count_in = k;
        s        = 1'b1;
        @(negedge clk);
        j = 0;
        while (busy === 1'b1 && j < 20) begin
            m = (j < keff) ? j : keff;
            check("build_pattern", 32'(pattern), 32'((1 << m) - 1));
            check("build_not_done", 32'(done), 32'd0);
            if (disturb && j == 1) begin
                count_in = 4'd6;
                s        = 1'b0;
            end
            j++;
            @(negedge clk);
        end
        check("busy_cycles", 32'(j), 32'(keff + 1));
        check("done_high", 32'(done), 32'd1);
        check("done_pattern", 32'(pattern), 32'(exp_word));
        check("done_ones", 32'(ones_shifted), 32'(keff));
        check("done_sat", 32'(sat), {31'd0, (k > 4'd8)});
        check("round_trip", 32'($countones(pattern)), 32'(keff));
        if (!disturb) begin
            for (int h = 0; h < done_hold; h++) begin
                @(negedge clk);
                check("done_hold", {30'd0, done, busy}, 32'b10);
                check("done_hold_pat", 32'(pattern), 32'(exp_word));
            end
            s = 1'b0;
        end
        @(negedge clk);
        check("idle_flags", {30'd0, done, busy}, 32'b00);
        check("idle_pattern", 32'(pattern), 32'(exp_word));
        check("idle_ones", 32'(ones_shifted), 32'(keff));
    endtask

    initial begin
        tests    = 0;
        failed   = 0;
        areset_n = 1'b0;
        s        = 1'b0;
        count_in = 4'd0;

        // Reset state
        #12;
        check("rst_pattern", 32'(pattern), 32'd0);
        check("rst_ones", 32'(ones_shifted), 32'd0);
        check("rst_flags", {29'd0, sat, done, busy}, 32'd0);
        @(negedge clk);
        areset_n = 1'b1;
        @(negedge clk);
        check("idle_after_rst", {30'd0, done, busy}, 32'd0);

        // Reset mid-BUILD after two shifts
        count_in = 4'd5;
        s        = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_pattern", 32'(pattern), 32'h03);
        #2 areset_n = 1'b0;
        #1;
        check("async_rst_pattern", 32'(pattern), 32'd0);
        check("async_rst_flags", {30'd0, done, busy}, 32'd0);
        s = 1'b0;
        @(negedge clk);
        areset_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", {30'd0, done, busy}, 32'd0);
        check("post_rst_pattern", 32'(pattern), 32'd0);

        // Directed runs
        run(4'd3, 3, 1'b0);
        run(4'd0, 1, 1'b0);
        run(4'd8, 1, 1'b0);
        run(4'hC, 2, 1'b0);
        run(4'd3, 0, 1'b1);

        // Round trip for every legal k
        for (int k = 0; k <= 8; k++) begin
            run(4'(k), 0, 1'b0);
        end

        // Randomized counts and DONE hold times
        for (int r = 0; r < 25; r++) begin
            run(4'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        failed++;
        $display("FAIL watchdog: observed timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $fatal(1, "timeout");
    end

endmodule
